// File: rtl/toggle_port_responder_if.sv
// Toggle req/ack request port plus valid/grant memory port of the toggle port responder.
interface toggle_port_responder_if #(
  parameter int unsigned AW = 23,
  parameter int unsigned DW = 16
);
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [DW-1:0] port_d;
  logic [DW-1:0] port_q;
  logic          mem_req;
  logic          mem_gnt;
  logic [AW-1:0] mem_a;
  logic [1:0]    mem_ds;
  logic          mem_we;
  logic [DW-1:0] mem_d;
  logic          mem_rvalid;
  logic [DW-1:0] mem_q;

  // Responder view: serves the request port, drives the memory port.
  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d, mem_gnt, mem_rvalid, mem_q,
    output port_ack, port_q, mem_req, mem_a, mem_ds, mem_we, mem_d
  );

  // Environment view: requester plus memory.
  modport master (
    output port_req, port_a, port_ds, port_we, port_d, mem_gnt, mem_rvalid, mem_q,
    input  port_ack, port_q, mem_req, mem_a, mem_ds, mem_we, mem_d
  );
endinterface

// File: rtl/toggle_port_responder.sv
// Responder for the toggle req/ack port: queues each request edge in a small FIFO and
// replays it on a valid/grant memory port, toggling port_ack once per completed access.
module toggle_port_responder #(
  parameter int unsigned AW         = 23,
  parameter int unsigned DW         = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  toggle_port_responder_if.slave  bus,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic          we;
    logic [DW-1:0] d;
  } req_t;

  logic [1:0]    state_q, state_d;
  logic          req_last_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  req_t          fifo_mem_q [DEPTH];
  req_t          mem_cmd_q, mem_cmd_d;
  logic          mem_req_q, mem_req_d;
  logic          port_ack_q, port_ack_d;
  logic [DW-1:0] port_q_q, port_q_d;
  logic          busy_q, busy_d;
  logic          overflow_q, overflow_d;

  logic          req_edge;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          bypass;
  req_t          in_req;
  req_t          head;

  always_comb begin
    in_req     = {bus.port_a, bus.port_ds, bus.port_we, bus.port_d};
    head       = fifo_mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    req_edge   = bus.port_req ^ req_last_q;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  end

  // Access sequencer; an edge into an idle, empty responder bypasses the FIFO.
  always_comb begin
    state_d    = state_q;
    mem_cmd_d  = mem_cmd_q;
    mem_req_d  = mem_req_q;
    port_ack_d = port_ack_q;
    port_q_d   = port_q_q;
    pop        = 1'b0;
    bypass     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          mem_cmd_d = head;
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
        end else if (req_edge) begin
          bypass    = 1'b1;
          mem_cmd_d = in_req;
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mem_gnt) begin
          mem_req_d = 1'b0;
          if (mem_cmd_q.we) begin
            port_ack_d = ~port_ack_q;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        if (bus.mem_rvalid) begin
          port_q_d   = bus.mem_q;
          port_ack_d = ~port_ack_q;
          state_d    = S_IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    push       = req_edge && !bypass && (!fifo_full || pop);
    overflow_d = overflow_q || (req_edge && fifo_full && !pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    busy_d     = (wr_ptr_d != rd_ptr_d) || (state_d != S_IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_last_q <= bus.port_req;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cmd_q  <= '0;
      mem_req_q  <= 1'b0;
      port_ack_q <= 1'b0;
      port_q_q   <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_last_q <= bus.port_req;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cmd_q  <= mem_cmd_d;
      mem_req_q  <= mem_req_d;
      port_ack_q <= port_ack_d;
      port_q_q   <= port_q_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: pointers alone define occupancy.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= in_req;
    end
  end

  assign bus.port_ack = port_ack_q;
  assign bus.port_q   = port_q_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_a    = mem_cmd_q.a;
  assign bus.mem_ds   = mem_cmd_q.ds;
  assign bus.mem_we   = mem_cmd_q.we;
  assign bus.mem_d    = mem_cmd_q.d;
  assign busy         = busy_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_toggle_port_responder.sv
// Bench for toggle_port_responder: directed scenarios plus randomized traffic, checked
// against a queue-based model of accepted requests and expected read-back data.
module tb_toggle_port_responder;

  localparam int unsigned AW    = 23;
  localparam int unsigned DW    = 16;
  localparam int unsigned DL    = 2;
  localparam int unsigned DEPTH = 1 << DL;
  localparam int unsigned RW    = AW + 2 + 1 + DW;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic busy;
  logic overflow;

  toggle_port_responder_if #(.AW(AW), .DW(DW)) bus ();

  toggle_port_responder #(.AW(AW), .DW(DW), .DEPTH_LOG2(DL)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_pass = 0;

  logic [RW-1:0] exp_q [$];
  logic [DW-1:0] cmp_q [$];
  int            acc_cnt  = 0;
  int            ack_seen = 0;
  logic          prev_ack = 1'b0;
  logic [DW-1:0] last_rd  = '0;

  int            gnt_mode   = 1;
  int            rd_fixed   = -1;
  logic          rd_fix_en  = 1'b0;
  logic [DW-1:0] rd_fix_val = '0;
  logic          force_rv   = 1'b0;
  logic [DW-1:0] force_q    = '0;
  logic          rd_pending = 1'b0;
  int            rd_wait    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Memory model: grants per gnt_mode, checks each accepted access against the request order.
  always @(negedge clk_sys) begin
    logic [RW-1:0] got;
    logic [DW-1:0] rdat;
    bus.mem_rvalid = 1'b0;
    if (reset) begin
      bus.mem_gnt = 1'b0;
      rd_pending  = 1'b0;
      last_rd     = '0;
      exp_q.delete();
      cmp_q.delete();
    end else begin
      if (force_rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_q      = force_q;
      end else if (rd_pending) begin
        if (rd_wait == 0) begin
          rdat           = rd_fix_en ? rd_fix_val : DW'($urandom);
          bus.mem_q      = rdat;
          bus.mem_rvalid = 1'b1;
          last_rd        = rdat;
          cmp_q.push_back(rdat);
          rd_pending     = 1'b0;
        end else begin
          rd_wait--;
        end
      end
      case (gnt_mode)
        0:       bus.mem_gnt = 1'b0;
        1:       bus.mem_gnt = 1'b1;
        default: bus.mem_gnt = 1'($urandom_range(0, 1));
      endcase
      if (bus.mem_req && bus.mem_gnt) begin
        got = {bus.mem_a, bus.mem_ds, bus.mem_we, bus.mem_d};
        if (exp_q.size() == 0) chk("spurious_access", 64'(got), 64'(0));
        else chk("access_fields", 64'(got), 64'(exp_q.pop_front()));
        if (bus.mem_we) begin
          cmp_q.push_back(last_rd);
        end else begin
          rd_pending = 1'b1;
          rd_wait    = (rd_fixed >= 0) ? rd_fixed : int'($urandom_range(0, 3));
        end
      end
    end
  end

  // Each ack toggle must carry the model's read-back value on port_q.
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_ack = bus.port_ack;
      ack_seen = 0;
    end else if (bus.port_ack !== prev_ack) begin
      prev_ack = bus.port_ack;
      ack_seen++;
      if (cmp_q.size() == 0) chk("spurious_ack", 64'(1), 64'(0));
      else chk("port_q_at_ack", 64'(bus.port_q), 64'(cmp_q.pop_front()));
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [1:0] ds, input logic we,
                      input logic [DW-1:0] d, input bit drop);
    @(negedge clk_sys);
    bus.port_a   = a;
    bus.port_ds  = ds;
    bus.port_we  = we;
    bus.port_d   = d;
    bus.port_req = ~bus.port_req;
    if (!drop) begin
      exp_q.push_back({a, ds, we, d});
      acc_cnt++;
    end
  endtask

  task automatic set_gnt(input int m);
    @(posedge clk_sys);
    gnt_mode = m;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset   = 1'b0;
    acc_cnt = 0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk_sys);
    while (k < 300 && !(busy == 1'b0 && exp_q.size() == 0 && cmp_q.size() == 0)) begin
      @(negedge clk_sys);
      k++;
    end
    chk({tag, "_drained"}, 64'(k < 300), 64'(1));
    chk({tag, "_ack_count"}, 64'(ack_seen), 64'(acc_cnt));
    chk({tag, "_ack_level"}, 64'(bus.port_ack), 64'(acc_cnt % 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.port_req = 1'b0;
    bus.port_a   = '0;
    bus.port_ds  = '0;
    bus.port_we  = 1'b0;
    bus.port_d   = '0;
    bus.mem_gnt  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_q    = '0;

    do_reset();
    chk("rst_port_ack", 64'(bus.port_ack), 64'(0));
    chk("rst_port_q",   64'(bus.port_q),   64'(0));
    chk("rst_mem_req",  64'(bus.mem_req),  64'(0));
    chk("rst_mem_a",    64'(bus.mem_a),    64'(0));
    chk("rst_busy",     64'(busy),         64'(0));
    chk("rst_overflow", 64'(overflow),     64'(0));

    // Single write with grant tied high.
    send(23'h000123, 2'b01, 1'b1, 16'h00AB, 1'b0);
    @(negedge clk_sys);
    chk("wr_mem_req", 64'(bus.mem_req), 64'(1));
    chk("wr_mem_a",   64'(bus.mem_a),   64'h123);
    chk("wr_mem_ds",  64'(bus.mem_ds),  64'(1));
    chk("wr_mem_we",  64'(bus.mem_we),  64'(1));
    chk("wr_mem_d",   64'(bus.mem_d),   64'hAB);
    chk("wr_busy",    64'(busy),        64'(1));
    @(negedge clk_sys);
    chk("wr_ack_latency", 64'(bus.port_ack), 64'(1));
    chk("wr_busy_done",   64'(busy),         64'(0));
    wait_idle("single");

    // Burst of four while the memory stalls.
    set_gnt(0);
    for (int i = 0; i < 4; i++) send(AW'(32'h100 + i), 2'(i), 1'b1, DW'(16'hA000 + i), 1'b0);
    repeat (10) @(negedge clk_sys);
    chk("burst_no_overflow", 64'(overflow), 64'(0));
    set_gnt(1);
    wait_idle("burst");
    chk("burst_ack_eq_req", 64'(bus.port_ack), 64'(bus.port_req));

    // Read with rvalid three cycles after grant.
    rd_fixed   = 2;
    rd_fix_en  = 1'b1;
    rd_fix_val = 16'hBEEF;
    send(23'h004000, 2'b11, 1'b0, 16'h5555, 1'b0);
    wait_idle("read");
    chk("read_port_q", 64'(bus.port_q), 64'hBEEF);
    rd_fixed  = -1;
    rd_fix_en = 1'b0;

    // Push lands in the cycle the full FIFO pops.
    set_gnt(0);
    for (int i = 0; i < 5; i++) send(AW'(32'h200 + i), 2'b00, 1'b1, DW'(i), 1'b0);
    repeat (2) @(negedge clk_sys);
    set_gnt(1);
    @(negedge clk_sys);
    send(23'h0002FF, 2'b10, 1'b1, 16'h0FF0, 1'b0);
    wait_idle("simul");
    chk("simul_no_overflow", 64'(overflow), 64'(0));

    // Overflow: sixth back-to-back edge with memory stalled is dropped.
    set_gnt(0);
    for (int i = 0; i < 6; i++) send(AW'(32'h300 + i), 2'b11, 1'b1, DW'(16'hC000 + i), i == 5);
    @(negedge clk_sys);
    chk("ovf_set", 64'(overflow), 64'(1));
    set_gnt(1);
    wait_idle("ovf");
    chk("ovf_sticky", 64'(overflow), 64'(1));

    do_reset();
    chk("rst2_overflow", 64'(overflow), 64'(0));
    chk("rst2_port_ack", 64'(bus.port_ack), 64'(0));

    // Reset while waiting for read data; late rvalid must be ignored.
    rd_fixed = 30;
    send(23'h000777, 2'b11, 1'b0, 16'h0, 1'b0);
    repeat (4) @(negedge clk_sys);
    chk("wrd_busy", 64'(busy), 64'(1));
    do_reset();
    rd_fixed = -1;
    @(posedge clk_sys);
    force_q  = 16'h1234;
    force_rv = 1'b1;
    @(posedge clk_sys);
    force_rv = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("late_rv_port_q",   64'(bus.port_q),   64'(0));
    chk("late_rv_port_ack", 64'(bus.port_ack), 64'(0));
    chk("late_rv_busy",     64'(busy),         64'(0));

    // Randomized traffic with random grants and read latencies, never exceeding capacity.
    set_gnt(2);
    for (int i = 0; i < 80; i++) begin
      int k;
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      k = 0;
      while (k < 200 && (acc_cnt - ack_seen) >= int'(DEPTH)) begin
        @(negedge clk_sys);
        k++;
      end
      if (k >= 200) chk("rand_outstanding_timeout", 64'(k), 64'(0));
      send(AW'($urandom), 2'($urandom), 1'($urandom), DW'($urandom), 1'b0);
    end
    wait_idle("random");
    chk("random_no_overflow", 64'(overflow), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
